// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
//   - state encodings for the access-sequencing FSM
//   - default address/data widths and the double-width load/store size
//   - latched request payload struct
package lsu_pkg;

    localparam int unsigned LSU_ADDR_WIDTH = 8;
    localparam int unsigned LSU_DATA_WIDTH = 8;
    localparam int unsigned WIDE_WIDTH     = 2 * LSU_DATA_WIDTH;
    localparam int unsigned STATE_WIDTH    = 3;

    typedef logic [STATE_WIDTH-1:0] lsu_state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LO      = 3'd1;
    localparam logic [2:0] ST_HI      = 3'd2;
    localparam logic [2:0] ST_RD_LAST = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef struct packed {
        logic                      write;
        logic                      wide;
        logic [LSU_ADDR_WIDTH-1:0] addr;
        logic [WIDE_WIDTH-1:0]     wdata;
    } lsu_req_t;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core byte or byte-pair request into one or two
// data_mem accesses, hides the memory's one-cycle read latency and returns a
// single-cycle completion pulse with the assembled load data.
// Ports:
//   CLK, Reset         clock, synchronous active-high reset
//   req_*              core request channel (valid/ready handshake)
//   resp_valid/rdata   one-cycle completion pulse and load result
//   DataAddress, ReadMem, WriteMem, DataIn, DataOut   data_mem interface
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = LSU_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = LSU_DATA_WIDTH
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_wide,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [2*DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0]   DataAddress,
    output logic                    ReadMem,
    output logic                    WriteMem,
    output logic [DATA_WIDTH-1:0]   DataIn,
    input  logic [DATA_WIDTH-1:0]   DataOut
);

    localparam int unsigned RD_WIDTH = 2 * DATA_WIDTH;

    lsu_state_t              state;
    lsu_state_t              state_next;
    lsu_req_t                req_q;
    logic [RD_WIDTH-1:0]     rdata;
    logic [RD_WIDTH-1:0]     rd_final;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [RD_WIDTH-1:0]     lat_wdata;
    logic                    mem_rd;
    logic                    mem_wr;
    logic                    accept;

    assign lat_addr  = ADDR_WIDTH'(req_q.addr);
    assign lat_wdata = RD_WIDTH'(req_q.wdata);

    // Ready only when idle and not being reset; enables are gated by Reset so
    // a reset landing mid-operation can never commit a write.
    assign req_ready = (state == ST_IDLE) && !Reset;
    assign accept    = req_valid && req_ready;
    assign ReadMem   = mem_rd && !Reset;
    assign WriteMem  = mem_wr && !Reset;

    // Last byte read arrives during RD_LAST; merge it with the captured low byte.
    assign rd_final = req_q.wide ? {DataOut, rdata[DATA_WIDTH-1:0]}
                                 : {{DATA_WIDTH{1'b0}}, DataOut};

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and memory-interface decode
    always_comb begin
        state_next  = state;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        DataAddress = '0;
        DataIn      = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) state_next = ST_LO;
            end
            ST_LO: begin
                DataAddress = lat_addr;
                DataIn      = lat_wdata[DATA_WIDTH-1:0];
                mem_wr      = req_q.write;
                mem_rd      = !req_q.write;
                if (req_q.wide)        state_next = ST_HI;
                else if (!req_q.write) state_next = ST_RD_LAST;
                else                   state_next = ST_DONE;
            end
            ST_HI: begin
                // Natural ADDR_WIDTH overflow gives the required wrap to 0.
                DataAddress = lat_addr + ADDR_WIDTH'(1);
                DataIn      = lat_wdata[RD_WIDTH-1:DATA_WIDTH];
                mem_wr      = req_q.write;
                mem_rd      = !req_q.write;
                state_next  = req_q.write ? ST_DONE : ST_RD_LAST;
            end
            ST_RD_LAST: state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Request latch, read-data assembly and response registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            req_q      <= '0;
            rdata      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= (state_next == ST_DONE);
            if (accept) begin
                req_q <= '{write: req_write,
                           wide:  req_wide,
                           addr:  LSU_ADDR_WIDTH'(req_addr),
                           wdata: WIDE_WIDTH'(req_wdata)};
            end
            if ((state == ST_HI) && !req_q.write) begin
                rdata[DATA_WIDTH-1:0] <= DataOut;
            end
            if (state == ST_RD_LAST) begin
                rdata      <= rd_final;
                resp_rdata <= rd_final;
            end else if (state_next == ST_DONE) begin
                resp_rdata <= '0;
            end
        end
    end

endmodule
